// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns engine, COLS_PER_CYCLE columns per RUN cycle.
// Single-entry valid/ready in, valid/ready out; result held until taken.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1,
  parameter bit INV_EN         = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int CPC = COLS_PER_CYCLE;
  localparam int N   = (CPC == 1) ? 4 : (CPC == 2) ? 2 : 1;
  localparam logic [1:0] LAST = 2'(N - 1);

  if (!(CPC == 1 || CPC == 2 || CPC == 4)) begin : g_bad_cpc
    $error("COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e       state_q;
  logic [1:0]   cnt_q;
  logic         mode_q;
  logic         ov_q;
  logic [127:0] work_q;
  logic [127:0] res_q;
  logic [127:0] res_d;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix(input logic [31:0] c, input logic inv);
    logic [7:0] a[4];
    logic [7:0] m2[4];
    logic [7:0] m4[4];
    logic [7:0] m8[4];
    logic [7:0] b[4];
    for (int i = 0; i < 4; i++) begin
      a[i]  = c[31-8*i -: 8];
      m2[i] = xt(a[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
    end
    for (int r = 0; r < 4; r++) begin
      if (INV_EN && inv) begin
        // 0e, 0b, 0d, 09 built from x2/x4/x8 partials
        b[r] = (m8[r] ^ m4[r] ^ m2[r])
             ^ (m8[(r+1)%4] ^ m2[(r+1)%4] ^ a[(r+1)%4])
             ^ (m8[(r+2)%4] ^ m4[(r+2)%4] ^ a[(r+2)%4])
             ^ (m8[(r+3)%4] ^ a[(r+3)%4]);
      end else begin
        b[r] = m2[r] ^ (m2[(r+1)%4] ^ a[(r+1)%4])
             ^ a[(r+2)%4] ^ a[(r+3)%4];
      end
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

  always_comb begin
    res_d = res_q;
    for (int g = 0; g < CPC; g++) begin
      int idx;
      idx = int'(cnt_q) * CPC + g;
      res_d[idx*32 +: 32] = mix(work_q[idx*32 +: 32], mode_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      ov_q    <= 1'b0;
      work_q  <= '0;
      res_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q  <= in_state;
            mode_q  <= INV_EN & in_inv;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          res_q <= res_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == LAST) begin
            state_q <= DONE;
            ov_q    <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
            ov_q    <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ov_q;
  assign out_state = res_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Bench for mix_columns_seq: four instances (CPC 1/2/4, CPC 1 without inverse),
// directed known-answer vectors plus a randomized handshake stream.
module tb_mix_columns_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         ivld[4];
  logic         iinv[4];
  logic         ordy[4];
  logic [127:0] ist[4];
  logic         irdy[4];
  logic         ov[4];
  logic         bsy[4];
  logic [127:0] ost[4];

  int tests = 0;
  int fails = 0;

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_2d26314c;
  localparam logic [127:0] E1 = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
  localparam logic [127:0] V2 = 128'hd4d4d4d5_c6c6c6c6_01010101_db135345;
  localparam logic [127:0] E2 = 128'hd5d5d7d6_c6c6c6c6_01010101_8e4da1bc;

  mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b1)) u0 (
    .clk(clk), .rst(rst), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .in_state(ist[0]), .in_inv(iinv[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_state(ost[0]), .busy(bsy[0]));
  mix_columns_seq #(.COLS_PER_CYCLE(2), .INV_EN(1'b1)) u1 (
    .clk(clk), .rst(rst), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .in_state(ist[1]), .in_inv(iinv[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_state(ost[1]), .busy(bsy[1]));
  mix_columns_seq #(.COLS_PER_CYCLE(4), .INV_EN(1'b1)) u2 (
    .clk(clk), .rst(rst), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .in_state(ist[2]), .in_inv(iinv[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .out_state(ost[2]), .busy(bsy[2]));
  mix_columns_seq #(.COLS_PER_CYCLE(1), .INV_EN(1'b0)) u3 (
    .clk(clk), .rst(rst), .in_valid(ivld[3]), .in_ready(irdy[3]),
    .in_state(ist[3]), .in_inv(iinv[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .out_state(ost[3]), .busy(bsy[3]));

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [127:0] mix_m(input logic [127:0] s, input logic inv);
    logic [7:0]   base[4];
    logic [7:0]   acc;
    logic [127:0] o = '0;
    if (inv) begin
      base[0] = 8'h0e; base[1] = 8'h0b; base[2] = 8'h0d; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc ^= gmul(base[(j - r + 4) % 4], s[c*32 + 24 - 8*j +: 8]);
        o[c*32 + 24 - 8*r +: 8] = acc;
      end
    return o;
  endfunction

  task automatic do_reset;
    for (int k = 0; k < 4; k++) begin
      ivld[k] = 1'b0; iinv[k] = 1'b0; ordy[k] = 1'b0; ist[k] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic xfer(input int k, input logic [127:0] s, input logic inv,
                      output logic [127:0] r, output int lat);
    ist[k] = s; iinv[k] = inv; ivld[k] = 1'b1; ordy[k] = 1'b0;
    @(negedge clk);
    ivld[k] = 1'b0; ist[k] = ~s; iinv[k] = ~inv;
    lat = 0;
    while (!ov[k] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    r = ost[k];
    if (!ov[k]) lat = -1;
  endtask

  task automatic release_out(input int k);
    ordy[k] = 1'b1;
    @(negedge clk);
    ordy[k] = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (irdy[k] !== 1'b1 || ov[k] !== 1'b0 || bsy[k] !== 1'b0 || ost[k] !== '0) begin
        fails++;
        $display("FAIL reset[%0d]: rdy=%b ov=%b busy=%b out=%h, need 1 0 0 0",
                 k, irdy[k], ov[k], bsy[k], ost[k]);
      end
    end
  endtask

  task automatic test_vector(input string nm, input int k, input logic [127:0] s,
                             input logic inv, input logic [127:0] e, input int elat);
    logic [127:0] r;
    int lat;
    xfer(k, s, inv, r, lat);
    tests++;
    if (r !== e) begin
      fails++;
      $display("FAIL %s data: got %h, need %h", nm, r, e);
    end
    tests++;
    if (lat !== elat) begin
      fails++;
      $display("FAIL %s latency: got %0d, need %0d", nm, lat, elat);
    end
    tests++;
    if (bsy[k] !== 1'b1 || irdy[k] !== 1'b0) begin
      fails++;
      $display("FAIL %s done_flags: busy=%b rdy=%b, need 1 0", nm, bsy[k], irdy[k]);
    end
    release_out(k);
    tests++;
    if (irdy[k] !== 1'b1 || ov[k] !== 1'b0) begin
      fails++;
      $display("FAIL %s release: rdy=%b ov=%b, need 1 0", nm, irdy[k], ov[k]);
    end
  endtask

  task automatic test_backpressure;
    logic [127:0] r;
    int lat;
    xfer(1, V2, 1'b0, r, lat);
    ivld[1] = 1'b1; ist[1] = V1; iinv[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      tests++;
      if (ov[1] !== 1'b1 || ost[1] !== E2 || irdy[1] !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold[%0d]: ov=%b rdy=%b out=%h, need 1 0 %h",
                 i, ov[1], irdy[1], ost[1], E2);
      end
    end
    ivld[1] = 1'b0;
    release_out(1);
    tests++;
    if (irdy[1] !== 1'b1 || ov[1] !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: rdy=%b ov=%b, need 1 0", irdy[1], ov[1]);
    end
  endtask

  task automatic test_rst_mid_run;
    bit seen = 1'b0;
    ist[0] = V1; iinv[0] = 1'b0; ivld[0] = 1'b1;
    @(negedge clk);
    ivld[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if (irdy[0] !== 1'b1 || ov[0] !== 1'b0 || ost[0] !== '0 || bsy[0] !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_run: rdy=%b ov=%b busy=%b out=%h, need 1 0 0 0",
               irdy[0], ov[0], bsy[0], ost[0]);
    end
    ordy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ov[0]) seen = 1'b1;
    end
    ordy[0] = 1'b0;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL rst_no_emit: out_valid seen=1, need 0");
    end
  endtask

  task automatic test_back_to_back(input int k, input int m);
    logic [127:0] q[$];
    logic [127:0] cval;
    logic [127:0] e;
    int  sent = 0;
    int  got  = 0;
    int  cyc  = 0;
    bit  pend = 1'b0;
    bit  cpend = 1'b0;
    ivld[k] = 1'b0; ordy[k] = 1'b0;
    while ((sent < m || got < m) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        q.push_back(mix_m(ist[k], iinv[k] & (k != 3)));
        sent++;
        ivld[k] = 1'b0;
      end
      if (cpend) begin
        got++;
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL b2b[%0d] extra: got %h, need none", k, cval);
        end else begin
          e = q.pop_front();
          if (cval !== e) begin
            fails++;
            $display("FAIL b2b[%0d] item %0d: got %h, need %h", k, got, cval, e);
          end
        end
      end
      if (!ivld[k] && sent < m && $urandom_range(0, 2) != 0) begin
        ivld[k] = 1'b1;
        ist[k]  = {$urandom, $urandom, $urandom, $urandom};
        iinv[k] = 1'($urandom_range(0, 1));
      end
      ordy[k] = ($urandom_range(0, 3) != 0);
      pend  = ivld[k] && irdy[k];
      cpend = ordy[k] && ov[k];
      cval  = ost[k];
    end
    ivld[k] = 1'b0; ordy[k] = 1'b0;
    tests++;
    if (got != m || q.size() != 0 || ov[k] !== 1'b0) begin
      fails++;
      $display("FAIL b2b[%0d] end: got=%0d left=%0d ov=%b, need %0d 0 0",
               k, got, q.size(), ov[k], m);
    end
  endtask

  initial begin
    test_reset();
    test_vector("fwd_cpc1", 0, V1, 1'b0, E1, 4);
    test_vector("inv_cpc4", 2, E1, 1'b1, V1, 1);
    test_vector("inv_cpc1", 0, E2, 1'b1, V2, 4);
    test_vector("fwd_cpc2", 1, V1, 1'b0, E1, 2);
    test_vector("fwd_cpc4", 2, V2, 1'b0, E2, 1);
    test_vector("inv_off", 3, V2, 1'b1, E2, 4);
    test_backpressure();
    test_rst_mid_run();
    test_reset();
    for (int k = 0; k < 4; k++) test_back_to_back(k, 250);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mix_columns_seq.md
MIX_COLUMNS_SEQ -- requirements
Module: mix_columns_seq

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, number of 32-bit columns transformed per RUN cycle; legal values 1, 2, 4.
REQ-002 Parameter INV_EN, default 1, when 1 the inverse MixColumns datapath is built; when 0 it is omitted.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  in_state/in_inv valid.
REQ-006 in_ready  output  1  block can accept a new state.
REQ-007 in_state  input  128  AES state; column c = bits [c*32+:32], row 0 = byte at c*32+24 (MSB of column).
REQ-008 in_inv  input  1  0 = forward MixColumns, 1 = InvMixColumns.
REQ-009 out_valid  output  1  out_state holds a completed result.
REQ-010 out_ready  input  1  downstream accepts out_state.
REQ-011 out_state  output  128  transformed state, same column/row layout as in_state.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE; N = 4/COLS_PER_CYCLE.
REQ-014 in_ready SHALL equal (state == IDLE); acceptance = in_valid && in_ready at a rising edge.
REQ-015 On acceptance: capture in_state into the working register, latch in_inv as mode (forced 0 when INV_EN=0), clear column counter, go to RUN.
REQ-016 Each RUN cycle SHALL transform columns [cnt*CPC .. cnt*CPC+CPC-1], write them into the result register, and increment cnt.
REQ-017 Forward mode per column (a0..a3, a0 = row 0): b0=2a0^3a1^a2^a3, b1=a0^2a1^3a2^a3, b2=a0^a1^2a2^3a3, b3=3a0^a1^a2^2a3.
REQ-018 Inverse mode: coefficient rows {0e,0b,0d,09} rotated identically per row.
REQ-019 All multiplies SHALL be GF(2^8) with reduction polynomial 0x11b (xtime: shift left, XOR 0x1b if bit 7 was set); results are 8-bit.
REQ-020 On the RUN edge processing the last group (cnt == N-1): go to DONE, assert out_valid; out_valid rises exactly N edges after the accepting edge.
REQ-021 In DONE, out_valid=1 and out_state SHALL be stable until out_valid && out_ready; on that edge go to IDLE and deassert out_valid.
REQ-022 out_ready low in DONE SHALL hold the result indefinitely; no new input is accepted in DONE or RUN.
REQ-023 Changes on in_state/in_inv/in_valid during RUN or DONE SHALL have no effect.
REQ-024 out_ready is ignored outside DONE; out_state outside DONE is don't-care but deterministic (last written value).
REQ-025 Illegal COLS_PER_CYCLE SHALL cause an elaboration-time error.

Reset
REQ-026 rst high at a rising edge SHALL force IDLE, cnt=0, mode=0, out_valid=0, busy=0, in_ready=1 (after the edge), out_state=0.
REQ-027 rst asserted in RUN or DONE SHALL abort the operation; the partial result is discarded and never presented.
REQ-028 rst has priority over any simultaneous handshake on the same edge.

Verification
REQ-029 Forward, CPC=1: in_state=128'hdb135345_f20a225c_01010101_2d26314c, in_inv=0 -> out_state=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, out_valid rises 4 edges after accept.
REQ-030 Inverse, CPC=4: in_state=128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inv=1 -> out_state=128'hdb135345_f20a225c_01010101_2d26314c, latency 1 edge.
REQ-031 Backpressure, CPC=2: hold out_ready=0 for 10 cycles in DONE -> out_valid stays 1, out_state unchanged, in_ready stays 0; release -> IDLE next edge.
REQ-032 Reset mid-RUN: assert rst at cnt=1 (CPC=1) -> next cycle in_ready=1, out_valid=0, out_state=0; no result is ever emitted for the aborted block.
REQ-033 INV_EN=0: in_inv=1 with 128'hd4d4d4d5_... column d4 d4 d4 d5 -> forward result column d5 d5 d7 d6.
REQ-034 Random back-to-back stream (1000 states, random in_valid/out_ready, all CPC) vs. software model -> all outputs match, in order, none dropped or duplicated.
